uart_prog_loader: RTL
=====================

// Module: uart_prog_loader
// PURPOSE
//  Serial-side front end of the instruction-memory programming path. Receives 8N1 UART bytes,
//  parses a length-prefixed little-endian word stream and emits one-cycle write strobes
//  (imem_din, imem_addr, imem_wea) with imem_prog_ena framing the load.
//  Feeds the imem programming port that the core's fetch stage reads while prog is high.
// PARAMETERS
//  CLKS_PER_BIT  868         clk cycles per UART bit (100 MHz / 115200); legal >= 4
//  BASE_ADDR     32'h0000_0000  byte address of the first loaded word
//  MAX_WORDS     4096        largest accepted word count N
// PORTS
//  clk            in   1   system clock
//  Rst            in   1   synchronous, active-low reset (0 = reset)
//  prog           in   1   load-mode enable; 0 aborts/idles the loader
//  rx             in   1   UART serial input, idle high, asynchronous
//  imem_din       out  32  assembled instruction word
//  imem_addr      out  32  byte address of imem_din
//  imem_wea       out  1   one-cycle write strobe
//  imem_prog_ena  out  1   high from header accepted until last word written or abort
//  prog_done      out  1   one-cycle pulse, load complete
//  frame_err      out  1   sticky: stop bit sampled 0; cleared on prog rising edge
//  len_err        out  1   sticky: N > MAX_WORDS; cleared on prog rising edge
// BEHAVIOUR
//  Reset (Rst=0 at clk edge): all outputs 0; imem_addr=BASE_ADDR; both FSMs idle; sync flops 1.
//  rx passes 2-flop synchroniser before use (2 cycle latency).
//  RX FSM: R_IDLE -(rx_s==0)-> R_START; R_START waits CLKS_PER_BIT/2, rx_s still 0 -> R_DATA,
//   else R_IDLE (glitch rejected). R_DATA samples 8 bits LSB first, each CLKS_PER_BIT apart,
//   at bit centre. R_STOP samples once: 1 -> byte_valid pulse; 0 -> frame_err=1, byte dropped.
//   Returns to R_IDLE right after stop sample (half-bit early, tolerates clock skew).
//  Load FSM (advances only on byte_valid):
//   L_IDLE: waits prog=1; byte count k=0.
//   L_LEN: 4 bytes -> N (little-endian). N==0 -> prog_done pulse, L_DONE (prog_ena never set).
//    N>MAX_WORDS -> len_err=1, L_DONE, no pulse. Else imem_prog_ena=1, L_DATA.
//   L_DATA: bytes shifted in LE; on 4th byte, next cycle imem_wea=1 with imem_din/imem_addr valid
//    that same cycle; then imem_addr+=4 (32-bit wrap), words_left-=1.
//    Last word: imem_prog_ena drops and prog_done pulses in the cycle after the final imem_wea.
//   L_DONE: ignores further bytes; prog=0 -> L_IDLE.
//  prog falling mid-load (any L_ state): next cycle imem_prog_ena=0, no further imem_wea,
//   partial word discarded, L_IDLE, imem_addr=BASE_ADDR; RX FSM finishes current byte.
//  prog rising edge: clears frame_err, len_err; imem_addr=BASE_ADDR.
//  Framing error mid-load does not abort; dropped byte shifts alignment (host must retry).
//  Bytes arriving while prog=0 are received and discarded.
//  Reset mid-operation: immediate return to reset state, no strobe in that cycle.
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined: after N words, 4 more bytes = 32-bit mod-2^32 sum of all
//   data words (LE). Extra port chk_err out 1 (sticky, cleared on prog rise, reset 0).
//   prog_done pulses after checksum word; mismatch sets chk_err alongside prog_done.
//   imem_prog_ena stays high until checksum word received. N==0 still expects checksum 0.
//  Not defined: no checksum phase, no chk_err port; prog_done after last data word.
// TESTING (CLKS_PER_BIT=4, BASE_ADDR=0)
//  1 Rst=0 3 cycles, rx=1 -> all outputs 0, imem_addr=0; hold Rst=0 with rx toggling -> no change.
//  2 prog=1, send 02 00 00 00, 13 05 10 00, 93 05 20 00 -> imem_wea at addr 0 din 0x00100513,
//    addr 4 din 0x00200593; prog_done 1 pulse; prog_ena low after.
//  3 rx low for 1 cycle only -> no byte; low with bad stop bit -> frame_err=1, no write.
//  4 header N=MAX_WORDS+1 -> len_err=1, imem_prog_ena never 1, no imem_wea.
//  5 N=3, prog=0 after 6 data bytes -> one write (addr 0) only, prog_ena=0 next cycle;
//    re-raise prog, full N=1 load -> write at addr 0, errors cleared.
//  6 CHECKSUM_EN: N=2 words above + sum 0x00300AA6 -> chk_err=0; sum 0 -> chk_err=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART (8N1) instruction-memory loader: length-prefixed little-endian word stream to imem write strobes.
// Optional trailing checksum word and chk_err port when UART_LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic        rx,
    output logic [31:0] imem_din,
    output logic [31:0] imem_addr,
    output logic        imem_wea,
    output logic        imem_prog_ena,
    output logic        prog_done,
    output logic        frame_err,
    output logic        len_err
`ifdef UART_LOADER_CHECKSUM_EN
   ,output logic        chk_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int WL_W  = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_CHK, L_DONE} ld_state_t;

    rx_state_t        rxState_q, rxState_d;
    logic             rxSync1_q, rxS_q;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]       rxBit_q, rxBit_d;
    logic [7:0]       rxShift_q, rxShift_d;
    logic             byteValid_q, byteValid_d;
    logic             stopBad_q, stopBad_d;

    ld_state_t        ldState_q, ldState_d;
    logic             progPrev_q;
    logic [1:0]       byteCnt_q, byteCnt_d;
    logic [31:0]      asmWord_q, asmWord_d;
    logic [WL_W-1:0]  wordsLeft_q, wordsLeft_d;
    logic [31:0]      din_q, din_d;
    logic [31:0]      addr_q, addr_d;
    logic             wea_q, wea_d;
    logic             progEna_q, progEna_d;
    logic             done_q, done_d;
    logic             frameErr_q, frameErr_d;
    logic             lenErr_q, lenErr_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
    logic             chkErr_q, chkErr_d;
`endif

    logic             progRise;
    logic [31:0]      fullWord;

    assign progRise = prog && !progPrev_q;
    assign fullWord = {rxShift_q, asmWord_q[31:8]};

    always_ff @(posedge clk) begin
        if (!Rst) begin
            rxSync1_q   <= 1'b1;
            rxS_q       <= 1'b1;
            rxState_q   <= R_IDLE;
            rxCnt_q     <= '0;
            rxBit_q     <= '0;
            rxShift_q   <= '0;
            byteValid_q <= 1'b0;
            stopBad_q   <= 1'b0;
        end else begin
            rxSync1_q   <= rx;
            rxS_q       <= rxSync1_q;
            rxState_q   <= rxState_d;
            rxCnt_q     <= rxCnt_d;
            rxBit_q     <= rxBit_d;
            rxShift_q   <= rxShift_d;
            byteValid_q <= byteValid_d;
            stopBad_q   <= stopBad_d;
        end
    end

    // Start is re-checked at half a bit so short glitches are rejected; later samples land mid-bit.
    always_comb begin
        rxState_d   = rxState_q;
        rxCnt_d     = rxCnt_q;
        rxBit_d     = rxBit_q;
        rxShift_d   = rxShift_q;
        byteValid_d = 1'b0;
        stopBad_d   = 1'b0;
        case (rxState_q)
            R_IDLE: begin
                rxCnt_d = '0;
                if (!rxS_q) rxState_d = R_START;
            end
            R_START: begin
                if (rxCnt_q == HALF_END) begin
                    rxCnt_d   = '0;
                    rxBit_d   = '0;
                    rxState_d = rxS_q ? R_IDLE : R_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxS_q, rxShift_q[7:1]};
                    rxBit_d   = rxBit_q + 3'd1;
                    if (rxBit_q == 3'd7) rxState_d = R_STOP;
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d     = '0;
                    byteValid_d = rxS_q;
                    stopBad_d   = !rxS_q;
                    rxState_d   = R_IDLE;
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            default: rxState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            ldState_q   <= L_IDLE;
            progPrev_q  <= 1'b0;
            byteCnt_q   <= '0;
            asmWord_q   <= '0;
            wordsLeft_q <= '0;
            din_q       <= '0;
            addr_q      <= BASE_ADDR;
            wea_q       <= 1'b0;
            progEna_q   <= 1'b0;
            done_q      <= 1'b0;
            frameErr_q  <= 1'b0;
            lenErr_q    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            chkErr_q    <= 1'b0;
`endif
        end else begin
            ldState_q   <= ldState_d;
            progPrev_q  <= prog;
            byteCnt_q   <= byteCnt_d;
            asmWord_q   <= asmWord_d;
            wordsLeft_q <= wordsLeft_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            wea_q       <= wea_d;
            progEna_q   <= progEna_d;
            done_q      <= done_d;
            frameErr_q  <= frameErr_d;
            lenErr_q    <= lenErr_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            chkErr_q    <= chkErr_d;
`endif
        end
    end

    // Dropping prog overrides every load state; the write strobe is registered one cycle after the 4th byte.
    always_comb begin
        ldState_d   = ldState_q;
        byteCnt_d   = byteCnt_q;
        asmWord_d   = asmWord_q;
        wordsLeft_d = wordsLeft_q;
        din_d       = din_q;
        addr_d      = addr_q;
        wea_d       = 1'b0;
        progEna_d   = progEna_q;
        done_d      = 1'b0;
        frameErr_d  = progRise ? 1'b0 : frameErr_q;
        lenErr_d    = progRise ? 1'b0 : lenErr_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        chkErr_d    = progRise ? 1'b0 : chkErr_q;
`endif
        if (stopBad_q) frameErr_d = 1'b1;
        if (progRise) addr_d = BASE_ADDR;

        if (!prog) begin
            ldState_d = L_IDLE;
            progEna_d = 1'b0;
            addr_d    = BASE_ADDR;
            byteCnt_d = '0;
        end else begin
            case (ldState_q)
                L_IDLE: begin
                    byteCnt_d = '0;
                    ldState_d = L_LEN;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                end
                L_LEN: begin
                    if (byteValid_q) begin
                        asmWord_d = fullWord;
                        byteCnt_d = byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            if (fullWord == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                ldState_d = L_CHK;
`else
                                done_d    = 1'b1;
                                ldState_d = L_DONE;
`endif
                            end else if (fullWord > 32'(MAX_WORDS)) begin
                                lenErr_d  = 1'b1;
                                ldState_d = L_DONE;
                            end else begin
                                progEna_d   = 1'b1;
                                wordsLeft_d = fullWord[WL_W-1:0];
                                ldState_d   = L_DATA;
                            end
                        end
                    end
                end
                L_DATA: begin
                    if (byteValid_q) begin
                        asmWord_d = fullWord;
                        byteCnt_d = byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            din_d = fullWord;
                            wea_d = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                            sum_d = sum_q + fullWord;
`endif
                        end
                    end
                    if (wea_q) begin
                        addr_d      = addr_q + 32'd4;
                        wordsLeft_d = wordsLeft_q - WL_W'(1);
                        if (wordsLeft_q == WL_W'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            ldState_d = L_CHK;
`else
                            progEna_d = 1'b0;
                            done_d    = 1'b1;
                            ldState_d = L_DONE;
`endif
                        end
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                L_CHK: begin
                    if (byteValid_q) begin
                        asmWord_d = fullWord;
                        byteCnt_d = byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            progEna_d = 1'b0;
                            done_d    = 1'b1;
                            if (fullWord != sum_q) chkErr_d = 1'b1;
                            ldState_d = L_DONE;
                        end
                    end
                end
`endif
                L_DONE: ldState_d = L_DONE;
                default: ldState_d = L_IDLE;
            endcase
        end
    end

    assign imem_din      = din_q;
    assign imem_addr     = addr_q;
    assign imem_wea      = wea_q;
    assign imem_prog_ena = progEna_q;
    assign prog_done     = done_q;
    assign frame_err     = frameErr_q;
    assign len_err       = lenErr_q;
`ifdef UART_LOADER_CHECKSUM_EN
    assign chk_err       = chkErr_q;
`endif

endmodule
